// File: rtl/moxie_ifetch_pkg.sv
// Shared constants and types for the Moxie Wishbone instruction-fetch unit.
package moxie_ifetch_pkg;

   localparam int              DEF_ADDR_WIDTH     = 32;
   localparam int              DEF_DATA_WIDTH     = 32;
   localparam int              DEF_DEPTH          = 4;
   localparam logic [31:0]     DEF_RESET_PC       = 32'h0000_1000;
   localparam int              DEF_BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] word;
      logic [DEF_ADDR_WIDTH-1:0] pc;
      logic                      err;
   } ifetch_entry_t;

endpackage

// File: rtl/moxie_ifetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with wrap-bit pointers; flush beats push/pop.
module moxie_ifetch_fifo
   import moxie_ifetch_pkg::*;
#(
   parameter int  DEPTH   = DEF_DEPTH,
   parameter type entry_t = ifetch_entry_t
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   push_i,
   input  entry_t                 entry_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output entry_t                 head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0] r_wr_ptr;
   logic [PW:0] r_rd_ptr;
   entry_t      r_mem [DEPTH];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop_i)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) r_mem[r_wr_ptr[PW-1:0]] <= entry_i;
   end

   assign head_o  = r_mem[r_rd_ptr[PW-1:0]];
   assign count_o = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/moxie_wb_ifetch.sv
// Wishbone classic instruction-fetch master feeding a prefetch buffer, with
// branch redirect/flush, in-flight squash and in-band bus error reporting.
module moxie_wb_ifetch
   import moxie_ifetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    DEPTH      = DEF_DEPTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   output logic [ADDR_WIDTH-1:0]     wb_adr_o,
   input  logic [DATA_WIDTH-1:0]     wb_dat_i,
   output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
   output logic                      wb_cyc_o,
   output logic                      wb_stb_o,
   output logic                      wb_we_o,
   input  logic                      wb_ack_i,
   input  logic                      wb_err_i,
   input  logic                      branch_flag_i,
   input  logic [ADDR_WIDTH-1:0]     branch_target_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [DATA_WIDTH-1:0]     word_o,
   output logic [ADDR_WIDTH-1:0]     pc_o,
   output logic                      err_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output fetch_state_t              dbg_state_o
);

   localparam int                    BPW        = DATA_WIDTH / 8;
   localparam int                    CW         = $clog2(DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPW - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] word;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  err;
   } entry_t;

   fetch_state_t          r_state;
   logic [ADDR_WIDTH-1:0] r_wb_adr;
   logic [ADDR_WIDTH-1:0] r_fetch_adr;
   logic [ADDR_WIDTH-1:0] r_first_pc;
   logic                  r_first;
   logic                  r_squash;

   logic                  w_retire;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_issue;
   logic [CW-1:0]         w_count;
   entry_t                w_push_entry;
   entry_t                w_head;

   // Handshake: an entry leaves the buffer on a clock edge where valid_o and
   // ready_i are both high; head fields hold steady while ready_i is low.
   assign w_retire = (r_state == ST_REQ) && (wb_ack_i || wb_err_i);
   assign w_push   = w_retire && !r_squash && !branch_flag_i;
   assign w_pop    = valid_o && ready_i;
   // Only one access can be outstanding, and it is only issued from IDLE, so
   // the credit check reduces to the current (un-popped) occupancy.
   assign w_issue  = (r_state == ST_IDLE) && !branch_flag_i && (w_count < CW'(DEPTH));

   assign w_push_entry.word = wb_err_i ? '0 : wb_dat_i;
   assign w_push_entry.pc   = r_first ? r_first_pc : r_fetch_adr;
   assign w_push_entry.err  = wb_err_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_wb_adr    <= RESET_PC & ALIGN_MASK;
         r_fetch_adr <= RESET_PC & ALIGN_MASK;
         r_first_pc  <= '0;
         r_first     <= 1'b0;
         r_squash    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state  <= ST_REQ;
                  r_wb_adr <= r_fetch_adr;
               end
            end
            ST_REQ: begin
               if (wb_ack_i || wb_err_i) begin
                  r_squash <= 1'b0;
                  r_state  <= (wb_err_i && !r_squash && !branch_flag_i) ? ST_HALT : ST_IDLE;
               end else if (branch_flag_i) begin
                  r_squash <= 1'b1;
               end
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_IDLE;
         endcase

         if (w_push) begin
            if (!wb_err_i) r_fetch_adr <= r_fetch_adr + ADDR_WIDTH'(BPW);
            r_first <= 1'b0;
         end

         // A redirect never coincides with a push, so these writes cannot clash.
         if (branch_flag_i) begin
            r_fetch_adr <= branch_target_i & ALIGN_MASK;
            r_first_pc  <= branch_target_i;
            r_first     <= 1'b1;
            if (r_state == ST_HALT) r_state <= ST_IDLE;
         end
      end
   end

   moxie_ifetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (w_push),
      .entry_i (w_push_entry),
      .pop_i   (w_pop),
      .flush_i (branch_flag_i),
      .head_o  (w_head),
      .count_o (w_count)
   );

   assign wb_adr_o    = r_wb_adr;
   assign wb_cyc_o    = (r_state == ST_REQ);
   assign wb_stb_o    = (r_state == ST_REQ);
   assign wb_sel_o    = '1;
   assign wb_we_o     = 1'b0;
   assign valid_o     = (w_count != '0);
   assign word_o      = valid_o ? w_head.word : '0;
   assign pc_o        = valid_o ? w_head.pc   : '0;
   assign err_o       = valid_o ? w_head.err  : 1'b0;
   assign level_o     = w_count;
   assign dbg_state_o = r_state;

endmodule
